// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the non-forwarding 5-stage MIPS-lite core.
//   It keeps a three-slot scoreboard (EX/MEM/WB) of in-flight destination
//   registers. It stalls IF/ID on RAW hazards and flushes IF/ID when execute
//   reports a taken branch or jump. It also drains the pipe after HALT and
//   keeps saturating stall/flush counters.
// Ports
//   clock, reset             : clock; synchronous active-high reset
//   id_valid/src1/src2/...   : decode-stage instruction fields
//   id_halt                  : decode instruction is HALT
//   ex_taken                 : execute stage resolved a taken branch/jump
//   stall, flush, fetch_en   : pipeline control outputs
//   halted                   : core fully drained after HALT
//   stall_cnt, flush_cnt     : saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int REG_WIDTH = 5,
  parameter int CNT_W     = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_WIDTH-1:0] id_src1,
  input  logic [REG_WIDTH-1:0] id_src2,
  input  logic                 id_uses_src2,
  input  logic [REG_WIDTH-1:0] id_dest,
  input  logic                 id_writes,
  input  logic                 id_halt,
  input  logic                 ex_taken,
  output logic                 stall,
  output logic                 flush,
  output logic                 fetch_en,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef struct packed {
    logic                 inst_v;
    logic                 wr_v;
    logic [REG_WIDTH-1:0] dest;
  } slot_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state, state_nxt;
  slot_t  ex_s, mem_s, wb_s, ex_nxt;
  logic   hazard, issue;

  // Register 0 is hardwired zero, so a source index of 0 never matches.
  function automatic logic hit(slot_t s, logic [REG_WIDTH-1:0] s1,
                               logic [REG_WIDTH-1:0] s2, logic use2);
    return s.wr_v && ((s1 != '0 && s.dest == s1) ||
                      (use2 && s2 != '0 && s.dest == s2));
  endfunction

  always_comb begin
    hazard = id_valid && (state == RUN) &&
             (hit(ex_s,  id_src1, id_src2, id_uses_src2) ||
              hit(mem_s, id_src1, id_src2, id_uses_src2) ||
              ((WB_BYPASS == 0) && hit(wb_s, id_src1, id_src2, id_uses_src2)));
    // A taken branch outranks the stall: the stalled instruction is on the
    // wrong path anyway.
    flush  = ex_taken && ex_s.inst_v && (state == RUN);
    stall  = hazard && !flush;
    issue  = id_valid && !stall && !flush && (state == RUN);
    ex_nxt.inst_v = issue;
    // HALT travels down the pipe as a non-writer.
    ex_nxt.wr_v   = issue && id_writes && !id_halt && (id_dest != '0);
    ex_nxt.dest   = id_dest;
  end

  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    halted    = 1'b0;
    case (state)
      RUN: begin
        fetch_en = !stall;
        if (id_halt && issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        // EX only receives bubbles here. When EX and MEM are empty now, all
        // three slots are empty after this edge, so halted rises together
        // with the pipe becoming empty.
        if (!ex_s.inst_v && !mem_s.inst_v) state_nxt = HALTED;
      end
      HALTED:  halted = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      ex_s  <= ex_nxt;
      mem_s <= ex_s;
      wb_s  <= mem_s;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=4, WB_BYPASS=1).
// The driver applies one vector per cycle and queues its hand-computed
// expected outputs. A negedge monitor pops the queue and compares.
module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0, id_uses_src2 = 1'b0, id_writes = 1'b0;
  logic       id_halt = 1'b0, ex_taken = 1'b0;
  logic [4:0] id_src1 = '0, id_src2 = '0, id_dest = '0;
  logic       stall, flush, fetch_en, halted;
  logic [3:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.REG_WIDTH(5), .CNT_W(4), .WB_BYPASS(1)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_uses_src2(id_uses_src2), .id_dest(id_dest),
    .id_writes(id_writes), .id_halt(id_halt), .ex_taken(ex_taken),
    .stall(stall), .flush(flush), .fetch_en(fetch_en), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tag;
    logic       st, fl, fe, ha;
    logic [3:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0, tag = 0;

  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (stall !== e.st || flush !== e.fl || fetch_en !== e.fe ||
          halted !== e.ha || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        n_bad++;
        $display("FAIL vec%0d: got stall=%b flush=%b fetch_en=%b halted=%b stall_cnt=%0d flush_cnt=%0d want stall=%b flush=%b fetch_en=%b halted=%b stall_cnt=%0d flush_cnt=%0d",
                 e.tag, stall, flush, fetch_en, halted, stall_cnt, flush_cnt,
                 e.st, e.fl, e.fe, e.ha, e.sc, e.fc);
      end
    end
  end

  // Apply one decode vector for a full cycle and queue its expected outputs.
  task automatic step(input logic v, input int s1, input int s2, input logic u2,
                      input int d, input logic w, input logic h, input logic tk,
                      input logic est, input logic efl, input logic efe,
                      input logic eha, input int esc, input int efc);
    exp_t e;
    id_valid = v; id_src1 = 5'(s1); id_src2 = 5'(s2); id_uses_src2 = u2;
    id_dest = 5'(d); id_writes = w; id_halt = h; ex_taken = tk;
    e.tag = tag; e.st = est; e.fl = efl; e.fe = efe; e.ha = eha;
    e.sc = 4'(esc); e.fc = 4'(efc);
    q.push_back(e);
    tag++;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    id_valid = 0; id_halt = 0; ex_taken = 0; id_writes = 0; id_uses_src2 = 0;
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
  endtask

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  initial begin
    do_reset();
    //   v s1 s2 u2 d  w h tk   st fl fe ha sc fc
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 0, 0);  // reset values
    // Back-to-back RAW: add r3 ; sub r4,r3,r5
    step(1, 1, 2, 1, 3, 1,0,0,  0, 0, 1, 0, 0, 0);
    step(1, 3, 5, 1, 4, 1,0,0,  1, 0, 0, 0, 0, 0);  // r3 in EX
    step(1, 3, 5, 1, 4, 1,0,0,  1, 0, 0, 0, 1, 0);  // r3 in MEM
    step(1, 3, 5, 1, 4, 1,0,0,  0, 0, 1, 0, 2, 0);  // r3 in WB: bypassed
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 2, 0);
    // Writer to r0 then reader of r0
    step(1, 1, 2, 1, 0, 1,0,0,  0, 0, 1, 0, 2, 0);
    step(1, 0, 0, 1, 5, 1,0,0,  0, 0, 1, 0, 2, 0);
    // rt match with id_uses_src2=0
    step(1, 1, 2, 1, 6, 1,0,0,  0, 0, 1, 0, 2, 0);
    step(1, 7, 6, 0, 0, 0,0,0,  0, 0, 1, 0, 2, 0);
    // Taken branch with a hazard in decode: flush wins over stall
    step(1, 1, 2, 1, 8, 1,0,0,  0, 0, 1, 0, 2, 0);
    step(1, 8, 0, 0, 9, 1,0,1,  0, 1, 1, 0, 2, 0);
    step(0, 0, 0, 0, 0, 0,0,1,  0, 0, 1, 0, 2, 1);  // EX is a bubble now
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 2, 1);
    // Halt drain with two older instructions in flight
    step(1, 1, 2, 1, 9, 1,0,0,  0, 0, 1, 0, 2, 1);
    step(1, 1, 2, 1,10, 1,0,0,  0, 0, 1, 0, 2, 1);
    step(1, 0, 0, 0, 0, 0,1,0,  0, 0, 1, 0, 2, 1);  // HALT issues
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 0, 0, 2, 1);  // EX=HALT
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 0, 0, 2, 1);  // MEM=HALT
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 0, 0, 2, 1);  // WB=HALT
    step(1, 9, 0, 0, 0, 0,0,0,  0, 0, 0, 1, 2, 1);  // pipe empty, halted
    step(1,10, 0, 0, 0, 0,0,1,  0, 0, 0, 1, 2, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 0, 0);  // back in RUN
    // HALT squashed by a taken branch is ignored
    step(1, 1, 2, 1,11, 1,0,0,  0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0,1,1,  0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 0, 1);
    step(1, 1, 2, 1, 0, 0,0,0,  0, 0, 1, 0, 0, 1);  // still accepting
    // Saturation: ten writer/reader pairs give 20 stall cycles
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 2, 1,12, 1,0,0,  0, 0, 1, 0, sat(2*i),   1);
      step(1,12, 0, 0, 0, 0,0,0,  1, 0, 0, 0, sat(2*i),   1);
      step(1,12, 0, 0, 0, 0,0,0,  1, 0, 0, 0, sat(2*i+1), 1);
      step(1,12, 0, 0, 0, 0,0,0,  0, 0, 1, 0, sat(2*i+2), 1);
    end
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 15, 1);
    step(0, 0, 0, 0, 0, 0,0,0,  0, 0, 1, 0, 15, 1);
    repeat (2) @(negedge clock);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
